icache_tag_array: RTL and testbench

ICACHE_TAG_ARRAY -- requirements
Module: icache_tag_array

---
 rtl/icache_pkg.sv | 19 +
 rtl/icache_tag_way_ram.sv | 23 ++
 rtl/icache_tag_array.sv | 165 ++++++++++++++++
 tb/tb_icache_tag_array.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants, derived-width helper and controller state encoding for the
// instruction-cache tag array.
package icache_pkg;

   localparam int DEF_TAG_BITS = 20;
   localparam int DEF_SET_BITS = 8;
   localparam int DEF_WAYS     = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   // A direct-mapped array still carries a 1-bit way field on its ports.
   function automatic int way_bits(input int ways);
      return (ways <= 1) ? 1 : $clog2(ways);
   endfunction

endpackage

// File: rtl/icache_tag_way_ram.sv
// One way of tag storage: synchronous registered read, read returns the
// contents from before a same-cycle write to the same address.
module icache_tag_way_ram #(
   parameter int DATA_BITS = 20,
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rd_en,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic [DATA_BITS-1:0] rd_data,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [DATA_BITS-1:0] wr_data
);

   logic [DATA_BITS-1:0] mem [1 << ADDR_BITS];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/icache_tag_array.sv
// Set-associative instruction-cache tag array with per-set round-robin victim
// pointers and a one-set-per-cycle flush. Optional macro: ICACHE_TAG_PARITY_EN.
//
//   state | meaning
//   IDLE  | ready_o high, lookups and fills accepted
//   FLUSH | clearing valid bits and rr pointer of set flush_cnt, one per cycle
module icache_tag_array
   import icache_pkg::*;
#(
   parameter  int TAG_BITS = DEF_TAG_BITS,
   parameter  int SET_BITS = DEF_SET_BITS,
   parameter  int WAYS     = DEF_WAYS,
   localparam int WAY_BITS = way_bits(WAYS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                lookup_valid_i,
   input  logic [SET_BITS-1:0] lookup_set_i,
   input  logic [TAG_BITS-1:0] lookup_tag_i,
   output logic                resp_valid_o,
   output logic                hit_o,
   output logic [WAY_BITS-1:0] hit_way_o,
   output logic [WAY_BITS-1:0] victim_way_o,
   input  logic                fill_i,
   input  logic [SET_BITS-1:0] fill_set_i,
   input  logic [WAY_BITS-1:0] fill_way_i,
   input  logic [TAG_BITS-1:0] fill_tag_i,
   input  logic                flush_i,
`ifdef ICACHE_TAG_PARITY_EN
   output logic                parity_err_o,
`endif
   output logic                ready_o
);

   localparam int SETS = 1 << SET_BITS;
`ifdef ICACHE_TAG_PARITY_EN
   localparam int ENTRY_BITS = TAG_BITS + 1;
`else
   localparam int ENTRY_BITS = TAG_BITS;
`endif

   state_t              state;
   logic [SET_BITS-1:0] flush_cnt;
   logic                ready_q;

   logic [WAYS-1:0]     valid_q [SETS];
   logic [WAY_BITS-1:0] rr_q    [SETS];

   logic                resp_q;
   logic [TAG_BITS-1:0] lk_tag_q;
   logic [WAYS-1:0]     lk_valid_q;
   logic [WAY_BITS-1:0] lk_rr_q;

   logic                  lk_acc;
   logic                  fill_acc;
   logic [ENTRY_BITS-1:0] wr_data;
   logic [ENTRY_BITS-1:0] rd_data [WAYS];
   logic [WAY_BITS-1:0]   rr_next;

   assign lk_acc   = lookup_valid_i && ready_q && !rst;
   assign fill_acc = fill_i && ready_q && !flush_i && !rst;
   assign ready_o  = ready_q;
   assign rr_next  = (WAYS == 1) ? '0 : rr_q[fill_set_i] + 1'b1;

`ifdef ICACHE_TAG_PARITY_EN
   // Even parity over {tag, valid=1, parity}: a good valid entry XORs to 1.
   assign wr_data = {~(^fill_tag_i), fill_tag_i};
`else
   assign wr_data = fill_tag_i;
`endif

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      icache_tag_way_ram #(
         .DATA_BITS(ENTRY_BITS),
         .ADDR_BITS(SET_BITS)
      ) u_ram (
         .clk     (clk),
         .rd_en   (lk_acc),
         .rd_addr (lookup_set_i),
         .rd_data (rd_data[w]),
         .wr_en   (fill_acc && (fill_way_i == WAY_BITS'(w))),
         .wr_addr (fill_set_i),
         .wr_data (wr_data)
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FLUSH;
         flush_cnt <= '0;
         ready_q   <= 1'b0;
         resp_q    <= 1'b0;
      end else begin
         resp_q <= lk_acc;
         if (lk_acc) begin
            lk_tag_q   <= lookup_tag_i;
            lk_valid_q <= valid_q[lookup_set_i];
            lk_rr_q    <= rr_q[lookup_set_i];
         end
         case (state)
            IDLE: begin
               if (flush_i) begin
                  state     <= FLUSH;
                  flush_cnt <= '0;
                  ready_q   <= 1'b0;
               end
            end
            FLUSH: begin
               flush_cnt <= flush_cnt + 1'b1;
               if (flush_cnt == '1) begin
                  state   <= IDLE;
                  ready_q <= 1'b1;
               end
            end
            default: state <= FLUSH;
         endcase
      end
   end

   // Snapshot above is taken with non-blocking reads, so a same-cycle fill is not seen.
   always_ff @(posedge clk) begin
      if (!rst && state == FLUSH) begin
         valid_q[flush_cnt] <= '0;
         rr_q[flush_cnt]    <= '0;
      end else if (fill_acc) begin
         valid_q[fill_set_i][fill_way_i] <= 1'b1;
         if (fill_way_i == rr_q[fill_set_i]) rr_q[fill_set_i] <= rr_next;
      end
   end

   logic [WAYS-1:0]     way_hit;
   logic [WAYS-1:0]     way_bad;
   logic [WAY_BITS-1:0] hit_way;
   logic [WAY_BITS-1:0] victim;

   always_comb begin
      way_hit = '0;
      way_bad = '0;
      for (int w = 0; w < WAYS; w++) begin
`ifdef ICACHE_TAG_PARITY_EN
         way_bad[w] = lk_valid_q[w] && !(^rd_data[w]);
`endif
         way_hit[w] = lk_valid_q[w] && !way_bad[w]
                      && (rd_data[w][TAG_BITS-1:0] == lk_tag_q);
      end
   end

   always_comb begin
      hit_way = '0;
      victim  = lk_rr_q;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (way_hit[w])     hit_way = WAY_BITS'(w);
         if (!lk_valid_q[w]) victim  = WAY_BITS'(w);
      end
   end

   assign resp_valid_o = resp_q;
   assign hit_o        = resp_q && (|way_hit);
   assign hit_way_o    = resp_q ? hit_way : '0;
   assign victim_way_o = resp_q ? victim : '0;
`ifdef ICACHE_TAG_PARITY_EN
   assign parity_err_o = resp_q && (|way_bad);
`endif

endmodule

// File: tb/tb_icache_tag_array.sv
// Randomized bench for icache_tag_array against a set/way table model; the
// parity scenario is compiled only when ICACHE_TAG_PARITY_EN is defined.
module tb_icache_tag_array;

   localparam int TAG_BITS = 20;
   localparam int SET_BITS = 8;
   localparam int WAYS     = 2;
   localparam int SETS     = 1 << SET_BITS;

   logic                clk = 1'b0;
   logic                rst;
   logic                lookup_valid;
   logic [SET_BITS-1:0] lookup_set;
   logic [TAG_BITS-1:0] lookup_tag;
   logic                resp_valid_o;
   logic                hit_o;
   logic [0:0]          hit_way_o;
   logic [0:0]          victim_way_o;
   logic                fill;
   logic [SET_BITS-1:0] fill_set;
   logic [0:0]          fill_way;
   logic [TAG_BITS-1:0] fill_tag;
   logic                flush;
   logic                ready_o;
`ifdef ICACHE_TAG_PARITY_EN
   logic                parity_err_o;
`endif

   icache_tag_array #(.TAG_BITS(TAG_BITS), .SET_BITS(SET_BITS), .WAYS(WAYS)) dut (
      .clk            (clk),
      .rst            (rst),
      .lookup_valid_i (lookup_valid),
      .lookup_set_i   (lookup_set),
      .lookup_tag_i   (lookup_tag),
      .resp_valid_o   (resp_valid_o),
      .hit_o          (hit_o),
      .hit_way_o      (hit_way_o),
      .victim_way_o   (victim_way_o),
      .fill_i         (fill),
      .fill_set_i     (fill_set),
      .fill_way_i     (fill_way),
      .fill_tag_i     (fill_tag),
      .flush_i        (flush),
`ifdef ICACHE_TAG_PARITY_EN
      .parity_err_o   (parity_err_o),
`endif
      .ready_o        (ready_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: what each set holds, and how many flush cycles remain.
   bit [TAG_BITS-1:0] m_tag [SETS][WAYS];
   bit                m_vld [SETS][WAYS];
   bit                m_bad [SETS][WAYS];
   int                m_rr  [SETS];
   int                flush_left = SETS;

   task automatic idle_inputs();
      lookup_valid = 1'b0; lookup_set = '0; lookup_tag = '0;
      fill = 1'b0; fill_set = '0; fill_way = '0; fill_tag = '0; flush = 1'b0;
   endtask

   task automatic step();
      bit acc_lk, e_hit, e_perr, found;
      int e_hw, e_vic, s;
      acc_lk = lookup_valid && (flush_left == 0) && !rst;
      s = int'(lookup_set);
      e_hit = 0; e_hw = 0; e_perr = 0; found = 0; e_vic = m_rr[s];
      for (int w = 0; w < WAYS; w++) begin
         if (m_vld[s][w] && m_bad[s][w]) e_perr = 1;
         if (!e_hit && m_vld[s][w] && !m_bad[s][w] && m_tag[s][w] == lookup_tag) begin
            e_hit = 1; e_hw = w;
         end
         if (!found && !m_vld[s][w]) begin
            found = 1; e_vic = w;
         end
      end
      @(posedge clk);
      if (rst) flush_left = SETS;
      else if (flush_left > 0) begin
         for (int w = 0; w < WAYS; w++) m_vld[SETS - flush_left][w] = 0;
         m_rr[SETS - flush_left] = 0;
         flush_left--;
      end else if (flush) flush_left = SETS;
      else if (fill) begin
         m_tag[fill_set][fill_way] = fill_tag;
         m_vld[fill_set][fill_way] = 1;
         m_bad[fill_set][fill_way] = 0;
         if (int'(fill_way) == m_rr[fill_set]) m_rr[fill_set] = (m_rr[fill_set] + 1) % WAYS;
      end
      #1;
      check("ready", 32'(ready_o), 32'(flush_left == 0));
      check("resp_valid", 32'(resp_valid_o), 32'(acc_lk));
      if (acc_lk) begin
         check("hit", 32'(hit_o), 32'(e_hit));
         check("hit_way", 32'(hit_way_o), 32'(e_hw));
         check("victim_way", 32'(victim_way_o), 32'(e_vic));
`ifdef ICACHE_TAG_PARITY_EN
         check("parity_err", 32'(parity_err_o), 32'(e_perr));
`endif
      end
   endtask

   task automatic do_fill(input int s, input int w, input int t);
      idle_inputs();
      fill = 1; fill_set = SET_BITS'(s); fill_way = 1'(w); fill_tag = TAG_BITS'(t);
      step();
   endtask

   task automatic do_lookup(input int s, input int t);
      idle_inputs();
      lookup_valid = 1; lookup_set = SET_BITS'(s); lookup_tag = TAG_BITS'(t);
      step();
      idle_inputs();
      step();
   endtask

   task automatic wait_ready(input string tag, input int exp_len);
      int n = 0;
      while (n < 2 * SETS) begin
         idle_inputs();
         lookup_valid = 1'($urandom_range(0, 1));
         lookup_set   = SET_BITS'($urandom);
         lookup_tag   = TAG_BITS'($urandom);
         step();
         n++;
         if (ready_o) break;
      end
      check(tag, 32'(n), 32'(exp_len));
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      repeat (3) step();
      check("rst_resp", 32'(resp_valid_o), 32'd0);
      check("rst_hit", 32'(hit_o), 32'd0);
      check("rst_victim", 32'(victim_way_o), 32'd0);
      rst = 0;
      wait_ready("flush_after_rst", SETS);

      do_fill(8'h12, 0, 20'h0ABCD);
      do_lookup(8'h12, 20'h0ABCD);
      check("d_hit_12", 32'(hit_o), 32'd0);

      do_fill(8'h05, 0, 20'h00111);
      do_fill(8'h05, 1, 20'h00222);
      do_lookup(8'h05, 20'h00333);
      do_fill(8'h05, 0, 20'h00444);
      do_lookup(8'h05, 20'h00333);

      idle_inputs();
      lookup_valid = 1; lookup_set = 8'h40; lookup_tag = 20'h00001;
      fill = 1; fill_set = 8'h40; fill_way = 0; fill_tag = 20'h00001;
      step();
      check("same_cycle_miss", 32'(hit_o), 32'd0);
      do_lookup(8'h40, 20'h00001);

      idle_inputs();
      lookup_valid = 1; lookup_set = 8'h40; lookup_tag = 20'h00001;
      step();
      check("repeat_hit", 32'(hit_o), 32'd1);

      for (int i = 0; i < 3000; i++) begin
         idle_inputs();
         lookup_valid = 1'($urandom_range(0, 1));
         lookup_set   = SET_BITS'($urandom_range(0, 3));
         lookup_tag   = TAG_BITS'($urandom_range(0, 3));
         fill         = 1'($urandom_range(0, 2) == 0);
         fill_set     = SET_BITS'($urandom_range(0, 3));
         fill_way     = 1'($urandom_range(0, 1));
         fill_tag     = TAG_BITS'($urandom_range(0, 3));
         flush        = 1'($urandom_range(0, 999) == 0);
         step();
      end
      wait_ready("settle", (flush_left == 0) ? 1 : flush_left);

      idle_inputs();
      flush = 1; fill = 1; fill_set = 8'h77; fill_way = 1; fill_tag = 20'h0BEEF;
      step();
      wait_ready("flush_len", SETS);
      do_lookup(8'h12, 20'h0ABCD);
      do_lookup(8'h40, 20'h00001);
      do_lookup(8'h77, 20'h0BEEF);

      idle_inputs();
      flush = 1;
      step();
      idle_inputs();
      repeat (100) step();
      rst = 1;
      step();
      rst = 0;
      wait_ready("rst_mid_flush", SETS);

`ifdef ICACHE_TAG_PARITY_EN
      do_fill(8'h12, 0, 20'h0ABCD);
      dut.g_way[0].u_ram.mem[8'h12][TAG_BITS] = ~dut.g_way[0].u_ram.mem[8'h12][TAG_BITS];
      m_bad[8'h12][0] = 1;
      idle_inputs();
      lookup_valid = 1; lookup_set = 8'h12; lookup_tag = 20'h0ABCD;
      step();
      check("par_hit", 32'(hit_o), 32'd0);
      check("par_err", 32'(parity_err_o), 32'd1);
      idle_inputs();
      step();
      check("par_err_pulse", 32'(parity_err_o), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
